bcd_count4: RTL and testbench

- Four-decade synchronous BCD counter; direct upstream stage of the 4-digit 7-segment multiplexed display driver.
- Produces the four BCD digit codes the display stage scans, plus run and overflow status.
- Counts on a 1-cycle enable pulse (Tick) from the system prescaler, e.g. 1 Hz or 100 Hz derived from the same clock.
- Start/stop is taken from a raw push-button level; clear is synchronous.

---
 rtl/bcd_count4_pkg.sv | 31 +++
 rtl/bcd_decade.sv | 35 +++
 rtl/bcd_count4.sv | 154 +++++++++++++++
 tb/tb_bcd_count4.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_count4_pkg.sv
// Shared BCD constants and helpers; digit index 1 is the most significant (the
// display driver scans digits in the same order).
package bcd_count4_pkg;

  localparam int          BCD_W      = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int          NUM_DIGITS = 4;

  typedef logic [BCD_W-1:0]            bcd_t;
  typedef logic [NUM_DIGITS*BCD_W-1:0] bcd_word_t;

  // Elaboration-time conversion of a decimal terminal count into packed BCD,
  // thousands digit in the top nibble.
  function automatic bcd_word_t max_to_bcd(input int value);
    bcd_word_t r;
    int        v;
    r = '0;
    v = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit idx of a packed BCD word, idx 1 = most significant.
  function automatic bcd_t bcd_digit(input bcd_word_t w, input int idx);
    return w[(NUM_DIGITS-idx)*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD digit register: clr > load > count step; co flags 9 (up) or 0 (down).
// Latency: 1 cycle from en to q; co is combinational from q and up; no backpressure.
module bcd_decade
  import bcd_count4_pkg::*;
(
  input  logic             CP,
  input  logic             nCR,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load_en,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] q,
  output logic             co
);

  assign co = up ? (q == BCD_MAX) : (q == '0);

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_val;
    end else if (en) begin
      if (up) begin
        q <= (q == BCD_MAX) ? '0 : q + 1'b1;
      end else begin
        q <= (q == '0) ? BCD_MAX : q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_count4.sv
// Four-decade up/down BCD counter with synchronized start/stop, sticky wrap flag and
// optional lap hold (BCD_COUNT4_LAP_HOLD_EN); outputs change on the Tick edge, no backpressure.
module bcd_count4
  import bcd_count4_pkg::*;
#(
  parameter int MAX_COUNT   = 9999,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CP,
  input  logic             nCR,
  input  logic             Tick,
  input  logic             StartStop,
  input  logic             Clr,
  input  logic             Up,
  input  logic             Lap,
  output logic [BCD_W-1:0] BCD1,
  output logic [BCD_W-1:0] BCD2,
  output logic [BCD_W-1:0] BCD3,
  output logic [BCD_W-1:0] BCD4,
  output logic             Running,
  output logic             Ovf
);

  localparam bcd_word_t MAX_BCD = max_to_bcd(MAX_COUNT);

  if (MAX_COUNT < 1 || MAX_COUNT > 9999) begin : g_bad_max
    $error("bcd_count4: MAX_COUNT out of range 1..9999");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("bcd_count4: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   ss_prev;
  logic                   ss_rise;

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      ss_sync <= '0;
      ss_prev <= 1'b0;
    end else begin
      ss_sync <= {ss_sync[SYNC_STAGES-2:0], StartStop};
      ss_prev <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign ss_rise = ss_sync[SYNC_STAGES-1] & ~ss_prev;

  // Clr is not in this path: it leaves the run state alone.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      Running <= 1'b0;
    end else begin
      Running <= Running ^ ss_rise;
    end
  end

  // Uses the registered Running, so a same-edge toggle does not affect this tick.
  logic step;
  assign step = Tick & Running & ~Clr;

  bcd_t      q     [1:NUM_DIGITS];
  logic      co    [1:NUM_DIGITS];
  logic      en    [1:NUM_DIGITS];
  bcd_word_t live;
  logic      at_term;
  logic      wrap;

  // Carry/borrow ripples from units (index NUM_DIGITS) up to thousands in one cycle.
  always_comb begin
    logic chain;
    for (int i = 1; i <= NUM_DIGITS; i++) begin
      en[i] = 1'b0;
    end
    chain = step;
    for (int i = NUM_DIGITS; i >= 1; i--) begin
      en[i] = chain;
      chain = chain & co[i];
    end
  end

  always_comb begin
    live = '0;
    for (int i = 1; i <= NUM_DIGITS; i++) begin
      live[(NUM_DIGITS-i)*BCD_W +: BCD_W] = q[i];
    end
  end

  assign at_term = Up ? (live == MAX_BCD) : (live == '0);
  assign wrap    = step & at_term;

  for (genvar i = 1; i <= NUM_DIGITS; i++) begin : g_dec
    bcd_decade u_dec (
      .CP       (CP),
      .nCR      (nCR),
      .en       (en[i]),
      .up       (Up),
      .clr      (Clr),
      .load_en  (wrap),
      .load_val (Up ? bcd_t'('0) : bcd_digit(MAX_BCD, i)),
      .q        (q[i]),
      .co       (co[i])
    );
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      Ovf <= 1'b0;
    end else if (Clr) begin
      Ovf <= 1'b0;
    end else if (wrap) begin
      Ovf <= 1'b1;
    end
  end

  bcd_word_t disp;

`ifdef BCD_COUNT4_LAP_HOLD_EN
  logic      lap_q;
  logic      held;
  bcd_word_t snap;
  logic      lap_rise;

  assign lap_rise = Lap & ~lap_q;

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      lap_q <= 1'b0;
      held  <= 1'b0;
      snap  <= '0;
    end else begin
      lap_q <= Lap;
      if (Clr) begin
        held <= 1'b0;
      end else if (lap_rise) begin
        held <= ~held;
        if (!held) begin
          snap <= live;
        end
      end
    end
  end

  // The live count keeps running underneath a held display.
  assign disp = held ? snap : live;
`else
  logic lap_unused;
  assign lap_unused = Lap;
  assign disp       = live;
`endif

  assign {BCD1, BCD2, BCD3, BCD4} = disp;

endmodule

// File: tb/tb_bcd_count4.sv
// Scoreboarded bench for bcd_count4: a 9999 instance (a) and a 59 instance (b).
module tb_bcd_count4;

  logic cp;
  logic n_cr;
  logic tick, ss, clr, up, lap;
  logic tick_b, ss_b, clr_b, up_b, lap_b;
  logic [3:0] a1, a2, a3, a4, b1, b2, b3, b4;
  logic a_run, a_ovf, b_run, b_ovf;

  bcd_count4 #(.MAX_COUNT(9999), .SYNC_STAGES(2)) dut_a (
    .CP(cp), .nCR(n_cr), .Tick(tick), .StartStop(ss), .Clr(clr), .Up(up), .Lap(lap),
    .BCD1(a1), .BCD2(a2), .BCD3(a3), .BCD4(a4), .Running(a_run), .Ovf(a_ovf)
  );

  bcd_count4 #(.MAX_COUNT(59), .SYNC_STAGES(2)) dut_b (
    .CP(cp), .nCR(n_cr), .Tick(tick_b), .StartStop(ss_b), .Clr(clr_b), .Up(up_b), .Lap(lap_b),
    .BCD1(b1), .BCD2(b2), .BCD3(b3), .BCD4(b4), .Running(b_run), .Ovf(b_ovf)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  typedef struct {
    logic [95:0] name;
    int          idx;
    bit          sel;
    logic [15:0] bcd;
    logic        run;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_pushed = 0;
  int   n_popped = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic cyc();
    @(posedge cp);
    #1;
  endtask

  task automatic expect_out(input logic [95:0] nm, input int idx, input bit sel,
                            input logic [15:0] bcd, input logic run, input logic ovf);
    exp_t e;
    e.name = nm; e.idx = idx; e.sel = sel; e.bcd = bcd; e.run = run; e.ovf = ovf;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic ticks(input bit sel, input int n);
    if (sel) tick_b = 1'b1; else tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
    tick_b = 1'b0;
  endtask

  task automatic clear(input bit sel);
    if (sel) clr_b = 1'b1; else clr = 1'b1;
    cyc();
    clr = 1'b0;
    clr_b = 1'b0;
  endtask

  // Monitor: pops each expectation as soon as it is queued and compares live outputs.
  initial begin
    exp_t        e;
    logic [15:0] act_bcd;
    logic        act_run, act_ovf;
    forever begin
      wait (n_pushed > n_popped);
      e = exp_q.pop_front();
      n_popped++;
      act_bcd = e.sel ? {b1, b2, b3, b4} : {a1, a2, a3, a4};
      act_run = e.sel ? b_run : a_run;
      act_ovf = e.sel ? b_ovf : a_ovf;
      checks++;
      if (act_bcd !== e.bcd || act_run !== e.run || act_ovf !== e.ovf) begin
        failures++;
        $display("FAIL %0s[%0d] dut%0d: got bcd=%h run=%b ovf=%b, want bcd=%h run=%b ovf=%b",
                 e.name, e.idx, e.sel, act_bcd, act_run, act_ovf, e.bcd, e.run, e.ovf);
      end
    end
  end

  // Digit legality on every cycle for both instances.
  always @(negedge cp) begin
    if (n_cr === 1'b1) begin
      checks++;
      if (a1 > 4'd9 || a2 > 4'd9 || a3 > 4'd9 || a4 > 4'd9 ||
          b1 > 4'd9 || b2 > 4'd9 || b3 > 4'd9 || b4 > 4'd9) begin
        failures++;
        $display("FAIL digit_range: a=%h%h%h%h b=%h%h%h%h, want every digit 0..9",
                 a1, a2, a3, a4, b1, b2, b3, b4);
      end
    end
  end

  // Start/stop sequence with Tick held high: StartStop level before edge k, and the
  // resulting count / Running after edge k (toggles land on the 3rd edge after a rise).
  bit          ss_tab  [20] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,
                                1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1};
  bit          run_tab [20] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,
                                1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
  logic [15:0] cnt_tab [20] = '{16'h0000,16'h0000,16'h0000,16'h0001,16'h0002,
                                16'h0003,16'h0004,16'h0005,16'h0006,16'h0007,
                                16'h0008,16'h0008,16'h0008,16'h0008,16'h0008,
                                16'h0008,16'h0008,16'h0008,16'h0009,16'h0010};

  initial begin
    logic lap_hold;
`ifdef BCD_COUNT4_LAP_HOLD_EN
    lap_hold = 1'b1;
`else
    lap_hold = 1'b0;
`endif
    n_cr = 1'b0;
    tick = 1'b0; ss = 1'b0; clr = 1'b0; up = 1'b1; lap = 1'b0;
    tick_b = 1'b0; ss_b = 1'b0; clr_b = 1'b0; up_b = 1'b1; lap_b = 1'b0;
    repeat (2) cyc();
    expect_out("reset", 0, 0, 16'h0000, 1'b0, 1'b0);
    expect_out("reset", 1, 1, 16'h0000, 1'b0, 1'b0);
    n_cr = 1'b1;
    cyc();

    tick = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ss = ss_tab[k];
      cyc();
      expect_out("ss_seq", k + 1, 0, cnt_tab[k], run_tab[k], 1'b0);
    end
    tick = 1'b0;
    ss = 1'b0;
    repeat (4) cyc();

    clear(0);
    expect_out("clr", 0, 0, 16'h0000, 1'b1, 1'b0);
    ticks(0, 98);
    expect_out("up98", 0, 0, 16'h0098, 1'b1, 1'b0);
    ticks(0, 1); expect_out("up99", 0, 0, 16'h0099, 1'b1, 1'b0);
    ticks(0, 1); expect_out("up100", 0, 0, 16'h0100, 1'b1, 1'b0);
    ticks(0, 1); expect_out("up101", 0, 0, 16'h0101, 1'b1, 1'b0);

    clear(0);
    ticks(0, 999);
    expect_out("up999", 0, 0, 16'h0999, 1'b1, 1'b0);
    ticks(0, 1); expect_out("carry3", 0, 0, 16'h1000, 1'b1, 1'b0);
    up = 1'b0;
    ticks(0, 1); expect_out("borrow3", 0, 0, 16'h0999, 1'b1, 1'b0);
    up = 1'b1;

    clear(0);
    ticks(0, 9999);
    expect_out("up9999", 0, 0, 16'h9999, 1'b1, 1'b0);
    ticks(0, 1); expect_out("upwrap", 0, 0, 16'h0000, 1'b1, 1'b1);
    ticks(0, 1); expect_out("ovf_stick", 0, 0, 16'h0001, 1'b1, 1'b1);
    clr = 1'b1; tick = 1'b1;
    cyc();
    clr = 1'b0; tick = 1'b0;
    expect_out("clr_tick", 0, 0, 16'h0000, 1'b1, 1'b0);
    up = 1'b0;
    ticks(0, 1); expect_out("dnwrap", 0, 0, 16'h9999, 1'b1, 1'b1);
    ticks(0, 1); expect_out("dn9998", 0, 0, 16'h9998, 1'b1, 1'b1);
    up = 1'b1;
    clear(0);
    expect_out("clr_ovf", 0, 0, 16'h0000, 1'b1, 1'b0);

    ss_b = 1'b1;
    cyc(); cyc();
    expect_out("b_start", 2, 1, 16'h0000, 1'b0, 1'b0);
    cyc();
    expect_out("b_start", 3, 1, 16'h0000, 1'b1, 1'b0);
    ss_b = 1'b0;
    repeat (3) cyc();
    up_b = 1'b0;
    ticks(1, 1); expect_out("b_dnwrap", 0, 1, 16'h0059, 1'b1, 1'b1);
    ticks(1, 1); expect_out("b_dn58", 0, 1, 16'h0058, 1'b1, 1'b1);
    up_b = 1'b1;
    clear(1);
    expect_out("b_clr", 0, 1, 16'h0000, 1'b1, 1'b0);
    ticks(1, 59); expect_out("b_up59", 0, 1, 16'h0059, 1'b1, 1'b0);
    ticks(1, 1); expect_out("b_upwrap", 0, 1, 16'h0000, 1'b1, 1'b1);

    clear(0);
    ticks(0, 537);
    expect_out("at537", 0, 0, 16'h0537, 1'b1, 1'b0);
    #3;
    n_cr = 1'b0;
    #1;
    expect_out("arst", 0, 0, 16'h0000, 1'b0, 1'b0);
    expect_out("arst", 1, 1, 16'h0000, 1'b0, 1'b0);
    cyc();
    n_cr = 1'b1;
    ticks(0, 1);
    expect_out("post_rst", 0, 0, 16'h0000, 1'b0, 1'b0);

    ss = 1'b1;
    repeat (3) cyc();
    expect_out("restart", 0, 0, 16'h0000, 1'b1, 1'b0);
    ss = 1'b0;
    repeat (3) cyc();
    ticks(0, 12);
    expect_out("at12", 0, 0, 16'h0012, 1'b1, 1'b0);
    lap = 1'b1; cyc(); lap = 1'b0;
    expect_out("lap_on", 0, 0, 16'h0012, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      ticks(0, 1);
      expect_out("lap_tick", k, 0, lap_hold ? 16'h0012 : 16'h0012 + 16'(k), 1'b1, 1'b0);
    end
    lap = 1'b1; cyc(); lap = 1'b0; cyc();
    expect_out("lap_off", 0, 0, 16'h0017, 1'b1, 1'b0);

    for (int i = 0; i < 20 && n_popped < n_pushed; i++) #1;
    if (n_popped < n_pushed) begin
      failures++;
      $display("FAIL drain: popped=%0d, want %0d", n_popped, n_pushed);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
